fwd_hazard_scoreboard: RTL and testbench
========================================

Name: fwd_hazard_scoreboard

Overview:
- Parametrised successor to the single-stage EX forwarding/load-stall logic.
- Holds a shift-register scoreboard of in-flight destination registers for NUM_STAGES stages past decode.
- Produces per-operand forwarding selects and a load-use stall for a pipeline of configurable depth and load latency.
- Sits between decode and the operand muxes; the pipeline controller consumes ld_stall.

Parameters:
- REG_W, 3, register address width (8 GPRs).
- NUM_STAGES, 3, tracked stages past decode (1=EX, 2=MEM, 3=WB).
- LOAD_LAT, 2, a load's data is forwardable only from stage index > LOAD_LAT.
- FLUSH_STAGES, 1, number of youngest stages invalidated on flush (1..NUM_STAGES).
- SEL_W, $clog2(NUM_STAGES+1), width of a forwarding select.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- adv  in  1  pipeline advance; 0 freezes the scoreboard
- flush  in  1  branch/exception flush
- dec_valid  in  1  decode holds a real instruction
- dec_wr_en  in  1  decode instruction writes a register
- dec_is_load  in  1  decode instruction is a load
- dec_dst  in  REG_W  decode destination register
- dec_src_a  in  REG_W  source A (Rs)
- dec_src_a_used  in  1  source A is read
- dec_src_b  in  REG_W  source B (Rt / store data)
- dec_src_b_used  in  1  source B is read
- fwd_a_sel  out  SEL_W  0=register file, k=forward from stage k
- fwd_b_sel  out  SEL_W  same, for operand B
- ld_stall  out  1  hold decode and insert a bubble
- stall_cnt  out  16  load-stall cycle count (optional feature)

Behaviour:
- Entry k (1..NUM_STAGES) holds {valid, wr_en, is_load, dst}. On rst low, all entries go invalid asynchronously; fwd_*_sel=0, ld_stall=0, stall_cnt=0.
- Match for operand X: the lowest k with valid & wr_en & dst==src_X & src_X_used & dec_valid. No match gives sel=0.
- Ready: the matched entry is ready if !is_load or k>LOAD_LAT. A ready match gives fwd_X_sel=k. A not-ready match gives fwd_X_sel=0 and requests a stall.
- Only the youngest match counts. An older ready match never overrides a younger not-ready one.
- ld_stall = stall request from A or B; purely combinational, same cycle as decode.
- On a clock edge with adv=1:
  - entry k <= entry k-1 for k>=2;
  - entry 1 <= decode instruction if dec_valid & !ld_stall & !flush, otherwise a bubble (valid=0).
- On a clock edge with adv=0: all entries hold. Outputs are recomputed from the held state and the current decode inputs.
- flush=1 and adv=1 together:
  - shift first;
  - then invalidate entries 1..FLUSH_STAGES;
  - the decode instruction is never inserted.
- flush=1 with adv=0: invalidate entries 1..FLUSH_STAGES in place.
- Simultaneous flush and ld_stall: flush wins; a bubble is inserted.
- R0 is an ordinary register and matches like any other (no zero-register rule).
- The stall resolves automatically: after LOAD_LAT+1-k advancing cycles the load reaches a ready stage.

Optional Feature:
- Macro FWD_STALL_CNT_EN.
- Defined: stall_cnt increments on each clock edge where ld_stall & adv; saturates at 16'hFFFF; cleared by rst.
- Undefined: no counter flops are built and stall_cnt is tied to 16'h0000.

Decomposition:
- Package fwd_pkg holds:
  - the sb_entry_t struct {valid, wr_en, is_load, dst};
  - the bubble constant SB_BUBBLE;
  - the sel-width helper function.
- Sub-module fwd_match: priority matcher over the entry array for one operand. Outputs are sel and stall_req. Instantiated twice (A, B).

Test Plan:
- ADD R3 enters, next decode reads src_a=R3 → fwd_a_sel=1, ld_stall=0. One cycle later → sel=2. Then sel=3. Then sel=0.
- LD R2 (LOAD_LAT=2) followed by a reader of R2 → ld_stall=1 for 2 cycles, bubbles inserted, then fwd_b_sel=3, ld_stall=0.
- Entry1 = ADD R1 and entry3 = ADD R1, decode reads R1 → fwd_a_sel=1 (youngest wins).
- Entry1 = LD R4 (not ready) and entry2 = ADD R4 → ld_stall=1, sel=0. Older ready match ignored.
- flush=1 with adv=1 and FLUSH_STAGES=1 → entry1 invalid next cycle; a matching reader gets sel=0. adv=0 while stalled → entries frozen, ld_stall held.
- rst asserted mid-stall → all outputs 0 immediately. With FWD_STALL_CNT_EN, 3 stall cycles → stall_cnt=3, then reset gives 0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard scoreboard: the in-flight entry
// record, the bubble constant and the forwarding-select width helper.
package fwd_pkg;

  // Entries store destinations at this width so any REG_W up to it fits.
  localparam int MAX_REG_W = 5;

  typedef struct packed {
    logic                 valid;
    logic                 wr_en;
    logic                 is_load;
    logic [MAX_REG_W-1:0] dst;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '{valid: 1'b0, wr_en: 1'b0, is_load: 1'b0, dst: '0};

  // A select must encode 0 (register file) plus every tracked stage.
  function automatic int sel_width(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority matcher for one source operand: finds the youngest in-flight
// writer of the source register and either forwards from it or, if it is a
// load whose data is not yet available, requests a stall.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int LOAD_LAT   = 2,
  parameter int SEL_W      = 2
) (
  input  sb_entry_t [NUM_STAGES:1] entries,
  input  logic [MAX_REG_W-1:0]     src,
  input  logic                     src_used,
  input  logic                     dec_valid,
  output logic [SEL_W-1:0]         sel,
  output logic                     stall_req
);

  logic found;

  // Scan youngest to oldest; the first hit decides, so an older ready
  // writer can never mask a younger load that is still in flight.
  always_comb begin
    sel       = '0;
    stall_req = 1'b0;
    found     = 1'b0;
    for (int k = 1; k <= NUM_STAGES; k++) begin
      if (!found && dec_valid && src_used && entries[k].valid &&
          entries[k].wr_en && (entries[k].dst == src)) begin
        found = 1'b1;
        if (!entries[k].is_load || (k > LOAD_LAT)) begin
          sel = SEL_W'(k);
        end else begin
          stall_req = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Shift-register scoreboard of in-flight destinations with per-operand
// forwarding selects and a load-use stall. Optional stall-cycle counter is
// built only when FWD_STALL_CNT_EN is defined; otherwise stall_cnt is 0.
module fwd_hazard_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_W        = 3,
  parameter int NUM_STAGES   = 3,
  parameter int LOAD_LAT     = 2,
  parameter int FLUSH_STAGES = 1,
  parameter int SEL_W        = sel_width(NUM_STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             flush,
  input  logic             dec_valid,
  input  logic             dec_wr_en,
  input  logic             dec_is_load,
  input  logic [REG_W-1:0] dec_dst,
  input  logic [REG_W-1:0] dec_src_a,
  input  logic             dec_src_a_used,
  input  logic [REG_W-1:0] dec_src_b,
  input  logic             dec_src_b_used,
  output logic [SEL_W-1:0] fwd_a_sel,
  output logic [SEL_W-1:0] fwd_b_sel,
  output logic             ld_stall,
  output logic [15:0]      stall_cnt
);

  sb_entry_t [NUM_STAGES:1] entries_q, entries_d;
  sb_entry_t                dec_entry;
  logic                     stall_a, stall_b;

  assign dec_entry = '{valid: 1'b1, wr_en: dec_wr_en, is_load: dec_is_load,
                       dst: MAX_REG_W'(dec_dst)};

  fwd_match #(.NUM_STAGES(NUM_STAGES), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) u_match_a (
    .entries   (entries_q),
    .src       (MAX_REG_W'(dec_src_a)),
    .src_used  (dec_src_a_used),
    .dec_valid (dec_valid),
    .sel       (fwd_a_sel),
    .stall_req (stall_a)
  );

  fwd_match #(.NUM_STAGES(NUM_STAGES), .LOAD_LAT(LOAD_LAT), .SEL_W(SEL_W)) u_match_b (
    .entries   (entries_q),
    .src       (MAX_REG_W'(dec_src_b)),
    .src_used  (dec_src_b_used),
    .dec_valid (dec_valid),
    .sel       (fwd_b_sel),
    .stall_req (stall_b)
  );

  assign ld_stall = stall_a | stall_b;

  // Next scoreboard state: shift on advance, then kill the youngest stages on flush.
  always_comb begin
    entries_d = entries_q;
    if (adv) begin
      for (int k = NUM_STAGES; k >= 2; k--) begin
        entries_d[k] = entries_q[k-1];
      end
      entries_d[1] = (dec_valid && !ld_stall && !flush) ? dec_entry : SB_BUBBLE;
    end
    if (flush) begin
      for (int k = 1; k <= NUM_STAGES; k++) begin
        if (k <= FLUSH_STAGES) begin
          entries_d[k] = SB_BUBBLE;
        end
      end
    end
  end

  // Scoreboard registers; reset empties every stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entries_q <= {NUM_STAGES{SB_BUBBLE}};
    end else begin
      entries_q <= entries_d;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where a stall actually costs a pipeline advance; saturate.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ld_stall && adv && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed bench for fwd_hazard_scoreboard with an in-bench pipeline model
// checked every cycle, plus literal expectations at key points.
module tb_fwd_hazard_scoreboard;

  localparam int NS = 3;
  localparam int LL = 2;
  localparam int FS = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       adv = 1'b1;
  logic       flush = 1'b0;
  logic       dec_valid = 1'b0;
  logic       dec_wr_en = 1'b0;
  logic       dec_is_load = 1'b0;
  logic [2:0] dec_dst = '0;
  logic [2:0] dec_src_a = '0;
  logic       dec_src_a_used = 1'b0;
  logic [2:0] dec_src_b = '0;
  logic       dec_src_b_used = 1'b0;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic       ld_stall;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad = 0;

  fwd_hazard_scoreboard #(.REG_W(3), .NUM_STAGES(NS), .LOAD_LAT(LL), .FLUSH_STAGES(FS)) dut (
    .clk(clk), .rst(rst), .adv(adv), .flush(flush),
    .dec_valid(dec_valid), .dec_wr_en(dec_wr_en), .dec_is_load(dec_is_load),
    .dec_dst(dec_dst), .dec_src_a(dec_src_a), .dec_src_a_used(dec_src_a_used),
    .dec_src_b(dec_src_b), .dec_src_b_used(dec_src_b_used),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ld_stall(ld_stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: %0d at %0t", name, act, $time);
    end
  endtask

  // Model: in-flight instructions by age (index 1 = youngest, issued last cycle).
  bit m_valid [1:NS];
  bit m_wr    [1:NS];
  bit m_ld    [1:NS];
  int m_dst   [1:NS];
  int m_cnt;

  // Youngest writer of src decides: forward if its data exists, else stall.
  function automatic void model_eval(input int src, input bit used, output int sel, output bit stall);
    sel = 0;
    stall = 1'b0;
    if (!(dec_valid && used)) return;
    for (int age = 1; age <= NS; age++) begin
      if (m_valid[age] && m_wr[age] && m_dst[age] == src) begin
        if (m_ld[age] && age <= LL) stall = 1'b1;
        else sel = age;
        return;
      end
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    int  sa, sb;
    bit  ta, tb;
    if (!rst) begin
      for (int i = 1; i <= NS; i++) begin
        m_valid[i] <= 1'b0; m_wr[i] <= 1'b0; m_ld[i] <= 1'b0; m_dst[i] <= 0;
      end
      m_cnt <= 0;
    end else begin
      model_eval(int'(dec_src_a), dec_src_a_used, sa, ta);
      model_eval(int'(dec_src_b), dec_src_b_used, sb, tb);
      if (adv) begin
        for (int i = 2; i <= NS; i++) begin
          m_valid[i] <= m_valid[i-1]; m_wr[i] <= m_wr[i-1];
          m_ld[i] <= m_ld[i-1]; m_dst[i] <= m_dst[i-1];
        end
        m_valid[1] <= dec_valid && !(ta || tb) && !flush;
        m_wr[1]    <= dec_wr_en;
        m_ld[1]    <= dec_is_load;
        m_dst[1]   <= int'(dec_dst);
      end
      if (flush) begin
        for (int i = 1; i <= FS; i++) m_valid[i] <= 1'b0;
      end
`ifdef FWD_STALL_CNT_EN
      if ((ta || tb) && adv && m_cnt < 65535) m_cnt <= m_cnt + 1;
`endif
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int  sa, sb;
    bit  ta, tb;
    if (rst) begin
      model_eval(int'(dec_src_a), dec_src_a_used, sa, ta);
      model_eval(int'(dec_src_b), dec_src_b_used, sb, tb);
      chk("cmp_sel_a", int'(fwd_a_sel), sa);
      chk("cmp_sel_b", int'(fwd_b_sel), sb);
      chk("cmp_stall", int'(ld_stall), int'(ta || tb));
      chk("cmp_cnt", int'(stall_cnt), m_cnt);
    end
  end

  task automatic set_dec(input bit v, input bit wr, input bit ld, input int dst,
                         input int sa, input bit sau, input int sb, input bit sbu);
    dec_valid = v; dec_wr_en = wr; dec_is_load = ld; dec_dst = 3'(dst);
    dec_src_a = 3'(sa); dec_src_a_used = sau; dec_src_b = 3'(sb); dec_src_b_used = sbu;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    set_dec(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) nxt();
  endtask

  initial begin
    #1;
    chk("rst_sel_a", int'(fwd_a_sel), 0);
    chk("rst_stall", int'(ld_stall), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    nxt();
    rst = 1'b1;
    idle(1);

    // ADD R3 then a reader: select walks 1,2,3,0
    set_dec(1, 1, 0, 3, 0, 0, 0, 0); nxt();
    set_dec(1, 0, 0, 0, 3, 1, 0, 0);
    @(negedge clk); chk("add_sel1", int'(fwd_a_sel), 1); chk("add_nostall", int'(ld_stall), 0); nxt();
    @(negedge clk); chk("add_sel2", int'(fwd_a_sel), 2); nxt();
    @(negedge clk); chk("add_sel3", int'(fwd_a_sel), 3); nxt();
    @(negedge clk); chk("add_sel0", int'(fwd_a_sel), 0); nxt();
    idle(3);

    // LD R2 then reader on B: two stall cycles, then forward from stage 3
    set_dec(1, 1, 1, 2, 0, 0, 0, 0); nxt();
    set_dec(1, 0, 0, 0, 0, 0, 2, 1);
    @(negedge clk); chk("ld_stall1", int'(ld_stall), 1); chk("ld_sel_b0", int'(fwd_b_sel), 0); nxt();
    @(negedge clk); chk("ld_stall2", int'(ld_stall), 1); nxt();
    @(negedge clk); chk("ld_sel_b3", int'(fwd_b_sel), 3); chk("ld_stall_off", int'(ld_stall), 0); nxt();
    idle(3);

    // Youngest of two writers wins; B reads R5 in stage 2
    set_dec(1, 1, 0, 1, 0, 0, 0, 0); nxt();
    set_dec(1, 1, 0, 5, 0, 0, 0, 0); nxt();
    set_dec(1, 1, 0, 1, 0, 0, 0, 0); nxt();
    set_dec(1, 0, 0, 0, 1, 1, 5, 1);
    @(negedge clk); chk("young_sel_a", int'(fwd_a_sel), 1); chk("young_sel_b", int'(fwd_b_sel), 2); nxt();
    idle(3);

    // Young not-ready load masks older ready ADD; freeze with adv=0
    set_dec(1, 1, 0, 4, 0, 0, 0, 0); nxt();
    set_dec(1, 1, 1, 4, 0, 0, 0, 0); nxt();
    set_dec(1, 0, 0, 0, 4, 1, 0, 0);
    @(negedge clk); chk("mask_stall", int'(ld_stall), 1); chk("mask_sel0", int'(fwd_a_sel), 0);
    adv = 1'b0; nxt();
    @(negedge clk); chk("frz_stall1", int'(ld_stall), 1); nxt();
    @(negedge clk); chk("frz_stall2", int'(ld_stall), 1); chk("frz_sel0", int'(fwd_a_sel), 0);
    adv = 1'b1; nxt();
    @(negedge clk); chk("mask_stall_k2", int'(ld_stall), 1); nxt();
    @(negedge clk); chk("mask_sel3", int'(fwd_a_sel), 3); chk("mask_release", int'(ld_stall), 0); nxt();
    idle(3);

    // Flush with advance: decode writer is dropped
    set_dec(1, 1, 0, 6, 0, 0, 0, 0); flush = 1'b1; nxt();
    flush = 1'b0; set_dec(1, 0, 0, 0, 6, 1, 0, 0);
    @(negedge clk); chk("flush_adv_sel0", int'(fwd_a_sel), 0); nxt();
    // Flush without advance: stage 1 is killed in place
    set_dec(1, 1, 0, 7, 0, 0, 0, 0); nxt();
    set_dec(0, 0, 0, 0, 0, 0, 0, 0); adv = 1'b0; flush = 1'b1; nxt();
    adv = 1'b1; flush = 1'b0; set_dec(1, 0, 0, 0, 7, 1, 0, 0);
    @(negedge clk); chk("flush_hold_sel0", int'(fwd_a_sel), 0); nxt();
    idle(3);

    // Flush during a load stall: bubble inserted, load keeps moving
    set_dec(1, 1, 1, 2, 0, 0, 0, 0); nxt();
    set_dec(1, 0, 0, 0, 2, 1, 0, 0); flush = 1'b1; nxt();
    flush = 1'b0;
    @(negedge clk); chk("flush_stall_k2", int'(ld_stall), 1); nxt();
    nxt();
    idle(3);

    // Reset in the middle of a stall clears outputs immediately
    set_dec(1, 1, 1, 5, 0, 0, 0, 0); nxt();
    set_dec(1, 0, 0, 0, 0, 0, 5, 1);
    @(negedge clk); chk("pre_rst_stall", int'(ld_stall), 1);
    #2; rst = 1'b0; #1;
    chk("mid_rst_stall", int'(ld_stall), 0);
    chk("mid_rst_sel_b", int'(fwd_b_sel), 0);
    chk("mid_rst_cnt", int'(stall_cnt), 0);
    nxt();
    rst = 1'b1;
    idle(2);

    // Pseudo-random traffic over a small register range (R0 included)
    for (int i = 0; i < 120; i++) begin
      set_dec(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 2) == 0),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      adv = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 7) == 0);
      nxt();
    end
    adv = 1'b1; flush = 1'b0;
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
